// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - opcode map, ALU function codes, result-select codes and FSM states.
// PAUSE exists only when CPU_SEQUENCER_SINGLE_STEP_EN is defined.
package cpu_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SRL  = 4'h7,
        OP_ADDI = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC,
        OP_JMP  = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    localparam logic [2:0] FS_ADD = 3'd0;
    localparam logic [2:0] FS_SUB = 3'd1;
    localparam logic [2:0] FS_AND = 3'd2;
    localparam logic [2:0] FS_OR  = 3'd3;
    localparam logic [2:0] FS_XOR = 3'd4;
    localparam logic [2:0] FS_NOT = 3'd5;
    localparam logic [2:0] FS_SLL = 3'd6;
    localparam logic [2:0] FS_SRL = 3'd7;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC  = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        , ST_PAUSE
`endif
    } state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction and data memory handshake bundle.
// master = sequencer side, slave = memory side.
interface cpu_sequencer_if #(
    parameter int INSTR_W = 16
);
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_req;
    logic               imem_ready;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ready;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_rdata, imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_rdata, imem_ready, dmem_ready
    );
endinterface

// File: rtl/cpu_sequencer_decode.sv
// rtl/cpu_sequencer_decode.sv - combinational opcode classifier feeding the sequencer FSM.
module cpu_sequencer_decode
    import cpu_sequencer_pkg::*;
(
    input  opcode_t    i_opcode,
    output logic [2:0] o_fs,
    output logic       o_mb,
    output logic       o_is_mem,
    output logic       o_is_store,
    output logic       o_is_branch,
    output logic       o_branch_pol,
    output logic       o_is_jmp,
    output logic       o_is_halt
);
    always_comb begin
        o_fs         = FS_ADD;
        o_mb         = 1'b0;
        o_is_mem     = 1'b0;
        o_is_store   = 1'b0;
        o_is_branch  = 1'b0;
        o_branch_pol = 1'b0;
        o_is_jmp     = 1'b0;
        o_is_halt    = 1'b0;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_SLL, OP_SRL: o_fs = i_opcode[2:0];
            OP_ADDI: o_mb = 1'b1;
            OP_LD:   o_is_mem = 1'b1;
            OP_ST: begin
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
            end
            // branch_pol = 1 means taken on a zero compare result
            OP_BEQ: begin
                o_fs         = FS_SUB;
                o_is_branch  = 1'b1;
                o_branch_pol = 1'b1;
            end
            OP_BNE: begin
                o_fs        = FS_SUB;
                o_is_branch = 1'b1;
            end
            OP_JMP:  o_is_jmp = 1'b1;
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle CPU sequencer: IR, PC and control FSM.
// Optional single-step gate selected by CPU_SEQUENCER_SINGLE_STEP_EN.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int OPCODE_W   = 4,
    parameter int PC_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_sequencer_if.master       mem,
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    input  logic                  step,
`endif
    input  logic                  alu_zero,
    input  logic [DATA_W-1:0]     reg_a_data,
    output logic [PC_W-1:0]       pc,
    output logic [REG_ADDR_W-1:0] da,
    output logic [REG_ADDR_W-1:0] aa,
    output logic [REG_ADDR_W-1:0] ba,
    output logic [2:0]            fs,
    output logic                  mb,
    output logic [DATA_W-1:0]     imm,
    output logic [1:0]            result_sel,
    output logic                  rw,
    output logic                  il,
    output logic                  halted
);
    localparam int INSTR_W = OPCODE_W + 3*REG_ADDR_W;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    localparam state_t ST_RESUME = ST_PAUSE;
`else
    localparam state_t ST_RESUME = ST_FETCH;
`endif

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_pc;

    opcode_t         w_opcode;
    logic [2:0]      w_fs;
    logic            w_mb, w_is_mem, w_is_store, w_is_branch, w_branch_pol, w_is_jmp, w_is_halt;
    logic            w_is_alu, w_taken, w_run;
    logic [PC_W-1:0] w_br_off;

    assign w_opcode = opcode_t'(r_ir[INSTR_W-1 -: OPCODE_W]);
    assign da       = r_ir[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign aa       = r_ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ba       = r_ir[REG_ADDR_W-1:0];

    cpu_sequencer_decode u_decode (
        .i_opcode     (w_opcode),
        .o_fs         (w_fs),
        .o_mb         (w_mb),
        .o_is_mem     (w_is_mem),
        .o_is_store   (w_is_store),
        .o_is_branch  (w_is_branch),
        .o_branch_pol (w_branch_pol),
        .o_is_jmp     (w_is_jmp),
        .o_is_halt    (w_is_halt)
    );

    assign w_is_alu = (w_opcode <= OP_ADDI);
    assign w_taken  = w_is_branch & (alu_zero == w_branch_pol);
    assign w_br_off = PC_W'($signed(da));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RESUME;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                ST_FETCH: if (mem.imem_ready) begin
                    r_ir    <= mem.imem_rdata;
                    r_pc    <= r_pc + PC_W'(1);
                    r_state <= ST_DECODE;
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (w_is_mem) begin
                        r_state <= ST_MEM;
                    end else if (w_is_halt) begin
                        r_state <= ST_HALT;
                    end else begin
                        // branch offset is relative to the already-incremented pc
                        if (w_taken)  r_pc <= r_pc + w_br_off;
                        if (w_is_jmp) r_pc <= PC_W'(reg_a_data);
                        r_state <= ST_RESUME;
                    end
                end
                ST_MEM:  if (mem.dmem_ready) r_state <= ST_RESUME;
                ST_HALT: r_state <= ST_HALT;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
                ST_PAUSE: if (step) r_state <= ST_FETCH;
`endif
                default: r_state <= ST_RESUME;
            endcase
        end
    end

    // strobes are held low while reset is asserted, whatever state is pending
    assign w_run        = ~reset;
    assign pc           = r_pc;
    assign fs           = w_fs;
    assign mb           = w_mb;
    assign imm          = DATA_W'(ba);
    assign mem.imem_req = w_run & (r_state == ST_FETCH);
    assign il           = mem.imem_req & mem.imem_ready;
    assign mem.dmem_req = w_run & (r_state == ST_MEM);
    assign mem.dmem_we  = mem.dmem_req & w_is_store;
    assign result_sel   = (mem.dmem_req & ~w_is_store & mem.dmem_ready) ? RES_MEM : RES_ALU;
    assign rw           = w_run & (((r_state == ST_EXEC) & w_is_alu) |
                                   ((r_state == ST_MEM) & ~w_is_store & mem.dmem_ready));
    assign halted       = w_run & (r_state == ST_HALT);
endmodule
